// File: rtl/hack_dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : hack_dmem_responder_if
//  Description : Bundles the CPU data-port signals and the framebuffer
//                posted-write stream used by hack_dmem_responder.
//                  CPU side   : dmem_addr_i[14:0], dmem_data_i[15:0],
//                               write_en_i, dmem_data_o[15:0]
//                  Screen FIFO: scr_addr_o[12:0], scr_data_o[15:0],
//                               scr_valid_o, scr_ready_i
//                The _i/_o suffixes are from the responder's point of view.
//                slave  = the responder, master = CPU / framebuffer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hack_dmem_responder_if;
    logic [14:0] dmem_addr_i;
    logic [15:0] dmem_data_i;
    logic        write_en_i;
    logic [15:0] dmem_data_o;

    logic [12:0] scr_addr_o;
    logic [15:0] scr_data_o;
    logic        scr_valid_o;
    logic        scr_ready_i;

    modport slave (
        input  dmem_addr_i,
        input  dmem_data_i,
        input  write_en_i,
        output dmem_data_o,
        output scr_addr_o,
        output scr_data_o,
        output scr_valid_o,
        input  scr_ready_i
    );

    modport master (
        output dmem_addr_i,
        output dmem_data_i,
        output write_en_i,
        input  dmem_data_o,
        input  scr_addr_o,
        input  scr_data_o,
        input  scr_valid_o,
        output scr_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/hack_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : hack_dmem_responder
//  Description : Hack data-memory responder. Serves the CPU data port with a
//                zero-latency read path over the Hack memory map:
//                  0x0000-0x3FFF  16K x 16 RAM
//                  0x4000-0x5FFF  8K x 16 screen shadow, writes also posted
//                                 to an external framebuffer through a FIFO
//                  0x6000         keyboard register (read only)
//                  anything else  reads 0, writes ignored
//                The CPU cannot stall, so a screen write arriving while the
//                FIFO is full (and not draining) is dropped and a sticky
//                overflow flag is raised.
//  Ports       : clk_i, reset_i    clock, synchronous active-high reset
//                bus (slave)       CPU data port + screen FIFO head
//                kbd_code_i        key code to load on a press
//                kbd_press_i       pulse: load kbd_code_i (wins over release)
//                kbd_release_i     pulse: clear key register
//                scr_overflow_o    sticky: a screen write was dropped
//                scr_level_o       FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_dmem_responder #(
    parameter int FIFO_DEPTH = 4,   // power of two, >= 2
    parameter int LVL_W      = 3    // must be able to hold FIFO_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    hack_dmem_responder_if.slave bus,
    input  logic [15:0]          kbd_code_i,
    input  logic                 kbd_press_i,
    input  logic                 kbd_release_i,
    output logic                 scr_overflow_o,
    output logic [LVL_W-1:0]     scr_level_o
);

    localparam int               c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] c_FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [14:0]      c_KBD_ADDR = 15'h6000;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [15:0]          r_ram    [16384];
    logic [15:0]          r_shadow [8192];
    logic [28:0]          r_fifo   [FIFO_DEPTH];   // {addr[12:0], data}

    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [15:0]          r_kbd;
    logic                 r_overflow;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_is_ram;
    logic w_is_scr;
    logic w_is_kbd;

    assign w_is_ram = ~bus.dmem_addr_i[14];
    assign w_is_scr = (bus.dmem_addr_i[14:13] == 2'b10);
    assign w_is_kbd = (bus.dmem_addr_i == c_KBD_ADDR);

    // ------------------------------------------------------------------
    // FIFO handshake
    // ------------------------------------------------------------------
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_accept;

    assign w_full   = (r_level == c_FULL_LVL);
    assign w_pop    = (r_level != '0) & bus.scr_ready_i;
    // A write during reset still lands in the shadow but never enters the
    // FIFO, since reset is discarding the queue anyway.
    assign w_push   = bus.write_en_i & w_is_scr & ~reset_i;
    // When full, the slot freed by a same-cycle pop is reused.
    assign w_accept = w_push & (~w_full | w_pop);

    // ------------------------------------------------------------------
    // Combinational read path. The CPU consumes inM in the same cycle, so
    // this is the pre-edge contents; same-cycle writes are not forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        bus.dmem_data_o = 16'h0000;
        if (w_is_ram) begin
            bus.dmem_data_o = r_ram[bus.dmem_addr_i[13:0]];
        end else if (w_is_scr) begin
            bus.dmem_data_o = r_shadow[bus.dmem_addr_i[12:0]];
        end else if (w_is_kbd) begin
            bus.dmem_data_o = r_kbd;
        end
    end

    // ------------------------------------------------------------------
    // RAM and screen shadow: no reset, contents survive reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (bus.write_en_i && w_is_ram) begin
            r_ram[bus.dmem_addr_i[13:0]] <= bus.dmem_data_i;
        end
        if (bus.write_en_i && w_is_scr) begin
            r_shadow[bus.dmem_addr_i[12:0]] <= bus.dmem_data_i;
        end
    end

    // FIFO data storage; only the pointers need a reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= {bus.dmem_addr_i[12:0], bus.dmem_data_i};
        end
    end

    // ------------------------------------------------------------------
    // FIFO control, overflow flag and keyboard register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_kbd      <= 16'h0000;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end

            if (kbd_press_i) begin
                r_kbd <= kbd_code_i;
            end else if (kbd_release_i) begin
                r_kbd <= 16'h0000;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.scr_valid_o = (r_level != '0);
    assign bus.scr_addr_o  = r_fifo[r_rd_ptr][28:16];
    assign bus.scr_data_o  = r_fifo[r_rd_ptr][15:0];
    assign scr_overflow_o  = r_overflow;
    assign scr_level_o     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_hack_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hack_dmem_responder
//  Description : Self-checking bench for hack_dmem_responder. A reference
//                model (associative-array memories, a queue for the posted
//                writes, scalars for key/overflow) is advanced by the
//                stimulus process; a separate monitor pops the expected
//                framebuffer entries whenever the DUT hands one over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_dmem_responder;

    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] kbd_code_i;
    logic        kbd_press_i;
    logic        kbd_release_i;
    logic        scr_overflow_o;
    logic [LVL_W-1:0] scr_level_o;

    hack_dmem_responder_if bus ();

    hack_dmem_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .bus            (bus),
        .kbd_code_i     (kbd_code_i),
        .kbd_press_i    (kbd_press_i),
        .kbd_release_i  (kbd_release_i),
        .scr_overflow_o (scr_overflow_o),
        .scr_level_o    (scr_level_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [15:0] ram_m    [int];
    logic [15:0] shadow_m [int];
    logic [28:0] exp_q    [$];     // posted writes the DUT must still emit
    logic [15:0] m_kbd = 16'h0000;
    logic        m_ovf = 1'b0;
    bit          armed = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check pre-edge state, advance model, wait.
    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [14:0] a, input logic [15:0] d, input logic we,
                         input logic rdy, input logic prs, input logic rel,
                         input logic [15:0] code, input logic rs);
        logic        known;
        logic [15:0] exp_rd;
        int          lvl;
        bit          pop;
        bit          push;
        bit          is_ram;
        bit          is_scr;

        bus.dmem_addr_i  = a;
        bus.dmem_data_i  = d;
        bus.write_en_i   = we;
        bus.scr_ready_i  = rdy;
        kbd_press_i      = prs;
        kbd_release_i    = rel;
        kbd_code_i       = code;
        reset_i          = rs;
        #1;

        is_ram = (a < 15'h4000);
        is_scr = (a >= 15'h4000) && (a < 15'h6000);

        if (armed) begin
            chk("level",    32'(scr_level_o),    32'(exp_q.size()));
            chk("valid",    32'(bus.scr_valid_o), 32'(exp_q.size() != 0));
            chk("overflow", 32'(scr_overflow_o), 32'(m_ovf));
            known  = 1'b1;
            exp_rd = 16'h0000;
            if (is_ram) begin
                if (ram_m.exists(int'(a))) exp_rd = ram_m[int'(a)];
                else known = 1'b0;
            end else if (is_scr) begin
                if (shadow_m.exists(int'(a) - 'h4000)) exp_rd = shadow_m[int'(a) - 'h4000];
                else known = 1'b0;
            end else if (a == 15'h6000) begin
                exp_rd = m_kbd;
            end
            if (known) chk("rdata", 32'(bus.dmem_data_o), 32'(exp_rd));
        end

        lvl  = exp_q.size();
        pop  = (lvl > 0) && rdy;
        push = we && is_scr && !rs;
        if (we && is_ram) ram_m[int'(a)] = d;
        if (we && is_scr) shadow_m[int'(a) - 'h4000] = d;
        if (rs) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_kbd = 16'h0000;
        end else begin
            if (push) begin
                if (lvl < FIFO_DEPTH || pop) exp_q.push_back({a[12:0], d});
                else m_ovf = 1'b1;
            end
            if (prs) m_kbd = code;
            else if (rel) m_kbd = 16'h0000;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d, input logic rdy);
        cycle(a, d, 1'b1, rdy, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic rd(input logic [14:0] a, input logic rdy);
        cycle(a, 16'h0, 1'b0, rdy, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic rst_cycle(input logic rdy);
        cycle(15'h0, 16'h0, 1'b0, rdy, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            rd(15'h7FFF, 1'b1);
            budget++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the expected entry whenever the DUT hands one over.
    // Runs after the stimulus process has settled its inputs for the cycle.
    // ------------------------------------------------------------------
    initial begin
        logic [28:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (armed && !reset_i && bus.scr_valid_o && bus.scr_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("scr_unexpected", 32'(bus.scr_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("scr_addr", 32'(bus.scr_addr_o), 32'(e[28:16]));
                    chk("scr_data", 32'(bus.scr_data_o), 32'(e[15:0]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [14:0] a;
        logic [15:0] d;
        logic        rdy;
        int          kind;

        bus.dmem_addr_i = '0;
        bus.dmem_data_i = '0;
        bus.write_en_i  = 1'b0;
        bus.scr_ready_i = 1'b0;
        kbd_code_i      = '0;
        kbd_press_i     = 1'b0;
        kbd_release_i   = 1'b0;
        reset_i         = 1'b1;

        rst_cycle(1'b0);
        armed = 1'b1;
        rst_cycle(1'b0);

        // RAM write/read, no same-cycle forwarding
        wr(15'h0010, 16'h1111, 1'b0);
        wr(15'h0010, 16'h1234, 1'b0);   // read in this cycle must show 0x1111
        rd(15'h0010, 1'b0);
        chk("t1_ram", 32'(bus.dmem_data_o), 32'h1234);

        // Screen posting with ready=1
        wr(15'h4005, 16'hBEEF, 1'b1);
        chk("t2_valid", 32'(bus.scr_valid_o), 32'd1);
        chk("t2_addr",  32'(bus.scr_addr_o),  32'h0005);
        chk("t2_data",  32'(bus.scr_data_o),  32'hBEEF);
        rd(15'h4005, 1'b1);
        chk("t2_level", 32'(scr_level_o), 32'd0);

        // Back-pressure and overflow
        for (int i = 0; i < 5; i++) wr(15'(15'h4000 + i), 16'(i + 1), 1'b0);
        chk("t3_level", 32'(scr_level_o),    32'd4);
        chk("t3_ovf",   32'(scr_overflow_o), 32'd1);
        for (int i = 0; i < 5; i++) rd(15'(15'h4000 + i), 1'b0);
        drain();

        // Full push + pop in the same cycle
        rst_cycle(1'b0);
        for (int i = 0; i < 4; i++) wr(15'(15'h4100 + i), 16'(16'hA0 + i), 1'b0);
        wr(15'h4110, 16'h00AA, 1'b1);
        chk("t4_level", 32'(scr_level_o),    32'd4);
        chk("t4_ovf",   32'(scr_overflow_o), 32'd0);
        drain();

        // Keyboard
        cycle(15'h6000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0041, 1'b0);
        rd(15'h6000, 1'b0);
        chk("t5_press", 32'(bus.dmem_data_o), 32'h0041);
        cycle(15'h6000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b0);
        rd(15'h6000, 1'b0);
        chk("t5_both", 32'(bus.dmem_data_o), 32'h0042);
        cycle(15'h6000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0099, 1'b0);
        wr(15'h6000, 16'hFFFF, 1'b0);
        rd(15'h6000, 1'b0);
        chk("t5_kbd_wr", 32'(bus.dmem_data_o), 32'h0000);
        wr(15'h6001, 16'h5555, 1'b0);
        rd(15'h6001, 1'b0);
        chk("t5_unmapped", 32'(bus.dmem_data_o), 32'h0000);

        // Reset mid-operation
        cycle(15'h7FFF, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0077, 1'b0);
        for (int i = 0; i < 5; i++) wr(15'(15'h4200 + i), 16'(16'hC0 + i), 1'b0);
        rd(15'h7FFF, 1'b1);
        chk("t6_pre_level", 32'(scr_level_o),    32'd3);
        chk("t6_pre_ovf",   32'(scr_overflow_o), 32'd1);
        rst_cycle(1'b0);
        chk("t6_valid", 32'(bus.scr_valid_o), 32'd0);
        chk("t6_level", 32'(scr_level_o),     32'd0);
        chk("t6_ovf",   32'(scr_overflow_o),  32'd0);
        rd(15'h6000, 1'b0);
        chk("t6_kbd", 32'(bus.dmem_data_o), 32'h0000);
        rd(15'h0010, 1'b0);
        chk("t6_ram", 32'(bus.dmem_data_o), 32'h1234);
        rd(15'h4005, 1'b0);
        chk("t6_shadow", 32'(bus.dmem_data_o), 32'hBEEF);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2, 3: a = ($urandom_range(0, 1) != 0) ? 15'(15'h0000 + $urandom_range(0, 7))
                                                             : 15'(15'h3FF8 + $urandom_range(0, 7));
                4, 5, 6, 9: a = ($urandom_range(0, 1) != 0) ? 15'(15'h4000 + $urandom_range(0, 7))
                                                             : 15'(15'h5FF8 + $urandom_range(0, 7));
                7:          a = 15'h6000;
                default:    a = ($urandom_range(0, 1) != 0) ? 15'h6001 : 15'h7FFF;
            endcase
            d   = 16'($urandom);
            // Alternate between mostly-ready and mostly-stalled phases.
            rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle(a, d, 1'($urandom_range(0, 1)), rdy,
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                  16'($urandom), 1'($urandom_range(0, 299) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hack_dmem_responder.md
Name: hack_dmem_responder

Overview:
- Data-memory responder on the far end of the CPU data port. It answers the CPU's address, write-data and write-enable signals, and returns read data.
- Implements the Hack memory map:
  - RAM at 0x0000-0x3FFF.
  - Screen at 0x4000-0x5FFF. Writes are held in a local shadow array and also posted to an external framebuffer through a valid/ready FIFO.
  - Keyboard register at 0x6000.
- The CPU cannot stall, so this block absorbs framebuffer back-pressure and flags any loss.

Parameters:
- FIFO_DEPTH, 4, number of entries in the screen posted-write FIFO; power of two, minimum 2.
- LVL_W, 3, width of the FIFO occupancy output; must hold the value FIFO_DEPTH.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- dmem_addr_i  in  15  word address from CPU.
- dmem_data_i  in  16  write data from CPU.
- write_en_i  in  1  CPU write strobe.
- dmem_data_o  out  16  read data to CPU; combinational.
- scr_addr_o  out  13  framebuffer word address (offset from 0x4000).
- scr_data_o  out  16  framebuffer write data.
- scr_valid_o  out  1  FIFO head valid.
- scr_ready_i  in  1  framebuffer accepts the head entry.
- kbd_code_i  in  16  key code from keyboard front end.
- kbd_press_i  in  1  one-cycle pulse: a key is pressed.
- kbd_release_i  in  1  one-cycle pulse: all keys are released.
- scr_overflow_o  out  1  sticky flag: a screen write was dropped from the FIFO.
- scr_level_o  out  LVL_W  FIFO occupancy.

Behaviour:
- Address decode:
  - RAM when addr[14]=0.
  - SCREEN when addr[14:13]=2'b10.
  - KBD when addr == 0x6000.
  - Any other address: reads return 0x0000 and writes are ignored.
- Read path:
  - dmem_data_o is a zero-latency combinational function of dmem_addr_i and current state, as the CPU expects inM in the same cycle.
  - A same-cycle write to the same address is not forwarded; the read returns the pre-edge value.
- RAM:
  - 16K x 16.
  - Written on the edge when write_en_i=1 and the address decodes to RAM.
  - Contents are not cleared by reset.
- SCREEN:
  - 8K x 16 shadow array, written unconditionally on a screen write. Reads of the screen region always come from the shadow, even if the FIFO dropped the write.
  - Each screen write also pushes {addr[12:0], data} into the FIFO.
  - The shadow array is not cleared by reset.
- FIFO:
  - Pop occurs when scr_valid_o & scr_ready_i.
  - scr_valid_o = (level != 0).
  - scr_addr_o and scr_data_o show the head entry. They are stable while scr_valid_o=1 and scr_ready_i=0.
  - Push when not full: entry accepted; it becomes visible at the head at the earliest one cycle later (no bypass).
  - Push when full and no pop in the same cycle: entry dropped, scr_overflow_o set to 1.
  - Push when full and pop in the same cycle: accepted, level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- KBD:
  - 16-bit key register. kbd_press_i loads kbd_code_i; kbd_release_i clears the register to 0.
  - If press and release pulse in the same cycle, press wins.
  - CPU writes to 0x6000 are ignored.
- scr_overflow_o: once set, it stays set until reset. No CPU-visible clear.
- Reset (synchronous; also applies mid-operation):
  - FIFO pointers and level go to 0, so scr_valid_o=0 and pending entries are discarded.
  - scr_level_o=0.
  - scr_overflow_o=0.
  - Key register goes to 0.
  - scr_addr_o and scr_data_o are don't-care while scr_valid_o=0.
  - Writes presented during a reset cycle update RAM and the shadow array but do not push into the FIFO.
- No internal state machine beyond FIFO control. The FIFO is the only sequential control state besides the key register and overflow flag.

Test Plan:
1. RAM: write 0x1234 to 0x0010, then read 0x0010 on the next cycle → 0x1234. In the write cycle itself, a read of 0x0010 returns the old value.
2. Screen posting: with scr_ready_i=1, write 0xBEEF to 0x4005 → next cycle scr_valid_o=1, scr_addr_o=0x0005, scr_data_o=0xBEEF; following cycle level=0. A read of 0x4005 returns 0xBEEF.
3. Back-pressure and overflow: with scr_ready_i=0, write 5 consecutive screen words (0x4000-0x4004, data 1-5) → level=4 and scr_overflow_o=1. Shadow reads return 1-5. Draining with ready=1 yields exactly addresses 0-3 with data 1-4, in order.
4. Full push and pop: with FIFO full, one cycle with both ready=1 and a screen write → no overflow, level stays 4, and the new entry emerges last.
5. Keyboard: press pulse with code 0x0041 → read 0x6000 returns 0x0041. Press and release in the same cycle with code 0x0042 → 0x0042. Release alone → 0x0000. CPU write to 0x6000 → no change. Read 0x6001 → 0x0000.
6. Reset mid-operation: with 3 entries queued and overflow set, assert reset_i for 1 cycle → scr_valid_o=0, level=0, overflow=0, key register 0. RAM and shadow contents written before reset remain readable.
